// File: rtl/audio_pkg.sv
// Shared types for the audio level controller: FSM state encoding, frame layout
// and the button index assignments on the board.
package audio_pkg;

  typedef enum logic [1:0] {
    PLAY      = 2'd0,
    RAMP_DOWN = 2'd1,
    MUTED     = 2'd2,
    RAMP_UP   = 2'd3
  } level_state_e;

  typedef struct packed {
    logic signed [23:0] left;
    logic signed [23:0] right;
  } stereo_frame_t;

  localparam int BTN_MUTE   = 1;
  localparam int BTN_VOL_DN = 2;
  localparam int BTN_VOL_UP = 3;

  // States in which the listener perceives the output as muted or going silent.
  function automatic logic is_mute_side(input level_state_e s);
    return (s == RAMP_DOWN) || (s == MUTED);
  endfunction

endpackage

// File: rtl/button_debounce.sv
// Synchronizes one raw board button and emits a single-cycle pulse when it has
// settled high for DEBOUNCE_P consecutive cycles after being settled low.
module button_debounce #(
  parameter int DEBOUNCE_P = 250000
) (
  input  logic clk_i,
  input  logic rstn_i,
  input  logic btn_i,
  output logic press_o
);

  localparam int CNT_W = (DEBOUNCE_P > 1) ? $clog2(DEBOUNCE_P) : 1;

  logic             sync1;
  logic             sync2;
  logic             stable;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      stable  <= 1'b0;
      cnt     <= '0;
      press_o <= 1'b0;
    end else begin
      sync1   <= btn_i;
      sync2   <= sync1;
      press_o <= 1'b0;
      // Any sample that agrees with the settled level restarts the qualification run.
      if (sync2 == stable) begin
        cnt <= '0;
      end else if (cnt == CNT_W'(DEBOUNCE_P - 1)) begin
        stable  <= sync2;
        cnt     <= '0;
        press_o <= sync2;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/audio_level_ctrl.sv
// Mute/volume sequencer for the stereo frame stream: debounced buttons drive an FSM
// whose target attenuation is approached one shift step per RAMP_FRAMES_P frames.
module audio_level_ctrl
  import audio_pkg::*;
#(
  parameter int WIDTH_P       = 24,
  parameter int DEBOUNCE_P    = 250000,
  parameter int RAMP_FRAMES_P = 64,
  parameter int MAX_SHIFT_P   = 7
) (
  input  logic                      clk_i,
  input  logic                      rstn_i,
  input  logic [3:1]                button_i,
  input  logic                      valid_i,
  output logic                      ready_o,
  input  logic signed [WIDTH_P-1:0] data_left_i,
  input  logic signed [WIDTH_P-1:0] data_right_i,
  output logic                      valid_o,
  input  logic                      ready_i,
  output logic signed [WIDTH_P-1:0] data_left_o,
  output logic signed [WIDTH_P-1:0] data_right_o,
  output logic [5:1]                led_o
);

  localparam int SHIFT_W = $clog2(MAX_SHIFT_P + 1);
  localparam int CNT_W   = (RAMP_FRAMES_P > 1) ? $clog2(RAMP_FRAMES_P) : 1;
  localparam logic [SHIFT_W-1:0] MAX_SHIFT = SHIFT_W'(MAX_SHIFT_P);

  logic [3:1]         press;
  level_state_e       state;
  level_state_e       state_next;
  logic [SHIFT_W-1:0] vol_r;
  logic [SHIFT_W-1:0] cur_shift_r;
  logic [SHIFT_W-1:0] target;
  logic [CNT_W-1:0]   frame_cnt;
  logic               accept;
  logic               at_target;
  logic               ramp_tick;
  logic               mute_p;
  logic               vol_inc;
  logic               vol_dec;
  logic signed [WIDTH_P-1:0] left_shifted;
  logic signed [WIDTH_P-1:0] right_shifted;

  genvar gi;
  generate
    for (gi = 1; gi <= 3; gi++) begin : g_btn
      button_debounce #(.DEBOUNCE_P(DEBOUNCE_P)) u_debounce (
        .clk_i   (clk_i),
        .rstn_i  (rstn_i),
        .btn_i   (button_i[gi]),
        .press_o (press[gi])
      );
    end
  endgenerate

  // A mute press swallows any volume press landing on the same cycle.
  assign mute_p  = press[BTN_MUTE];
  assign vol_inc = press[BTN_VOL_DN] & ~press[BTN_VOL_UP] & ~mute_p;
  assign vol_dec = press[BTN_VOL_UP] & ~press[BTN_VOL_DN] & ~mute_p;

  assign ready_o   = ~valid_o | ready_i;
  assign accept    = valid_i & ready_o;
  assign target    = ((state == PLAY) || (state == RAMP_UP)) ? vol_r : MAX_SHIFT;
  assign at_target = (cur_shift_r == target);
  assign ramp_tick = accept & ~at_target & (frame_cnt == CNT_W'(RAMP_FRAMES_P - 1));

  // Shift into dedicated signed nets so the arithmetic shift is never widened unsigned.
  always_comb begin
    left_shifted  = data_left_i >>> cur_shift_r;
    right_shifted = data_right_i >>> cur_shift_r;
  end

  always_comb begin
    state_next = state;
    case (state)
      PLAY:      if (mute_p) state_next = RAMP_DOWN;
      RAMP_DOWN: begin
        if (mute_p)                              state_next = RAMP_UP;
        else if (accept && cur_shift_r == MAX_SHIFT) state_next = MUTED;
      end
      MUTED:     if (mute_p) state_next = RAMP_UP;
      RAMP_UP: begin
        if (mute_p)                    state_next = RAMP_DOWN;
        else if (cur_shift_r == vol_r) state_next = PLAY;
      end
      default:   state_next = PLAY;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state        <= PLAY;
      vol_r        <= '0;
      cur_shift_r  <= '0;
      frame_cnt    <= '0;
      valid_o      <= 1'b0;
      data_left_o  <= '0;
      data_right_o <= '0;
    end else begin
      state <= state_next;

      if (vol_inc && vol_r < MAX_SHIFT)
        vol_r <= vol_r + 1'b1;
      else if (vol_dec && vol_r != '0)
        vol_r <= vol_r - 1'b1;

      if (at_target)
        frame_cnt <= '0;
      else if (accept)
        frame_cnt <= ramp_tick ? '0 : frame_cnt + 1'b1;

      if (ramp_tick)
        cur_shift_r <= (target > cur_shift_r) ? cur_shift_r + 1'b1 : cur_shift_r - 1'b1;

      if (ready_o)
        valid_o <= valid_i;

      if (accept) begin
        data_left_o  <= (state == MUTED) ? '0 : left_shifted;
        data_right_o <= (state == MUTED) ? '0 : right_shifted;
      end
    end
  end

  assign led_o = {~at_target, 3'(vol_r), is_mute_side(state)};

endmodule

// File: tb/tb_audio_level_ctrl.sv
// Bench for audio_level_ctrl: directed table, hand-written button sequences and a
// randomized phase, all checked against a frame-level reference model and a scoreboard.
module tb_audio_level_ctrl;
  import audio_pkg::*;

  localparam int W  = 24;
  localparam int DB = 4;
  localparam int RF = 2;
  localparam int MS = 7;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                rstn_i;
  logic [3:1]          button_i;
  logic                valid_i;
  logic                ready_o;
  logic signed [W-1:0] data_left_i;
  logic signed [W-1:0] data_right_i;
  logic                valid_o;
  logic                ready_i;
  logic signed [W-1:0] data_left_o;
  logic signed [W-1:0] data_right_o;
  logic [5:1]          led_o;

  audio_level_ctrl #(.WIDTH_P(W), .DEBOUNCE_P(DB), .RAMP_FRAMES_P(RF), .MAX_SHIFT_P(MS)) dut (
    .clk_i(clk), .rstn_i(rstn_i), .button_i(button_i), .valid_i(valid_i), .ready_o(ready_o),
    .data_left_i(data_left_i), .data_right_i(data_right_i), .valid_o(valid_o), .ready_i(ready_i),
    .data_left_o(data_left_o), .data_right_o(data_right_o), .led_o(led_o)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state
  level_state_e m_state;
  int           m_vol, m_shift, m_cnt;
  logic         m_valid;
  int           m_left, m_right;
  logic [3:1]   m_press;
  logic [3:1]   m_stable;
  logic [DB+1:0] hist [1:3];
  int           sb_l[$], sb_r[$];
  int           stream_mode;
  int           track[$];
  logic         track_en;

  typedef struct {
    logic v; logic r; stereo_frame_t in;
    logic ev; logic er; stereo_frame_t ex;
  } vec_t;
  vec_t vecs [6];

  function automatic int u24(input logic [23:0] x);
    return int'({8'h00, x});
  endfunction

  // Floor division by 2^s: what a sign-preserving attenuation must produce.
  function automatic int asr(input int v, input int s);
    int d, q;
    d = 1 << s;
    q = v / d;
    if (v < 0 && q * d != v) q = q - 1;
    return q;
  endfunction

  function automatic int m_target();
    return (m_state == PLAY || m_state == RAMP_UP) ? m_vol : MS;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = PLAY; m_vol = 0; m_shift = 0; m_cnt = 0;
    m_valid = 1'b0; m_left = 0; m_right = 0;
    m_press = '0; m_stable = '0;
    for (int b = 1; b <= 3; b++) hist[b] = '0;
    sb_l.delete(); sb_r.delete();
  endtask

  task automatic model_edge(input logic v, input logic r, input int l, input int rr,
                            input logic [3:1] raw, input logic deliv, input int dl, input int dr);
    int tgt, n_shift, n_cnt, n_vol, el, er;
    level_state_e n_state;
    logic acc, mute_p, inc, dec;
    logic [3:1] np;
    logic [DB-1:0] win;
    tgt = m_target();
    acc = v & (~m_valid | r);
    mute_p = m_press[1];
    inc = m_press[2] & ~m_press[3] & ~mute_p;
    dec = m_press[3] & ~m_press[2] & ~mute_p;

    if (deliv) begin
      if (sb_l.size() == 0) begin
        check("sb_empty", 1, 0);
      end else begin
        el = sb_l.pop_front(); er = sb_r.pop_front();
        check("sb_left", dl, el);
        check("sb_right", dr, er);
      end
    end
    if (acc) begin
      m_left  = (m_state == MUTED) ? 0 : asr(l, m_shift);
      m_right = (m_state == MUTED) ? 0 : asr(rr, m_shift);
      sb_l.push_back(u24(m_left[23:0]));
      sb_r.push_back(u24(m_right[23:0]));
    end

    n_shift = m_shift; n_cnt = m_cnt;
    if (m_shift == tgt) n_cnt = 0;
    else if (acc) begin
      if (m_cnt == RF - 1) begin
        n_cnt = 0;
        n_shift = (tgt > m_shift) ? m_shift + 1 : m_shift - 1;
      end else n_cnt = m_cnt + 1;
    end

    n_state = m_state;
    case (m_state)
      PLAY:      if (mute_p) n_state = RAMP_DOWN;
      RAMP_DOWN: if (mute_p) n_state = RAMP_UP; else if (acc && m_shift == MS) n_state = MUTED;
      MUTED:     if (mute_p) n_state = RAMP_UP;
      default:   if (mute_p) n_state = RAMP_DOWN; else if (m_shift == m_vol) n_state = PLAY;
    endcase

    n_vol = m_vol;
    if (inc && m_vol < MS) n_vol = m_vol + 1;
    else if (dec && m_vol > 0) n_vol = m_vol - 1;

    if (~m_valid | r) m_valid = v;
    m_shift = n_shift; m_cnt = n_cnt; m_state = n_state; m_vol = n_vol;

    // A press is recognised once the last DB synchronized samples are all high.
    for (int b = 1; b <= 3; b++) begin
      hist[b] = {hist[b][DB:0], raw[b]};
      win = hist[b][DB+1:2];
      np[b] = 1'b0;
      if (&win && !m_stable[b]) begin
        m_stable[b] = 1'b1; np[b] = 1'b1;
      end else if (~|win && m_stable[b]) begin
        m_stable[b] = 1'b0;
      end
    end
    m_press = np;
  endtask

  task automatic compare_outputs();
    logic [5:1] e;
    e[1] = (m_state == RAMP_DOWN) || (m_state == MUTED);
    e[4:2] = 3'(m_vol);
    e[5] = (m_shift != m_target());
    check("valid_o", valid_o, m_valid);
    check("ready_o", ready_o, !m_valid || ready_i);
    check("led_o", led_o, e);
    check("data_left_o", u24(data_left_o), u24(m_left[23:0]));
    check("data_right_o", u24(data_right_o), u24(m_right[23:0]));
    if (track_en && valid_o && (track.size() == 0 || track[$] != u24(data_left_o)))
      track.push_back(u24(data_left_o));
  endtask

  task automatic drive_stream();
    case (stream_mode)
      1: begin
        valid_i = 1'b1; ready_i = 1'b1;
        data_left_i = 24'h400000; data_right_i = 24'hC00000;
      end
      2: begin
        valid_i = ($urandom_range(0, 3) != 0);
        ready_i = ($urandom_range(0, 3) != 0);
        data_left_i = 24'($urandom); data_right_i = 24'($urandom);
      end
      default: ;
    endcase
  endtask

  task automatic step();
    logic v, r, deliv;
    logic [3:1] raw;
    int l, rr, dl, dr;
    v = valid_i; r = ready_i; raw = button_i;
    l = data_left_i; rr = data_right_i;
    deliv = valid_o & ready_i;
    dl = u24(data_left_o); dr = u24(data_right_o);
    @(posedge clk);
    if (!rstn_i) model_reset();
    else model_edge(v, r, l, rr, raw, deliv, dl, dr);
    #1;
    compare_outputs();
    drive_stream();
  endtask

  task automatic press(input logic [3:1] mask, input int hold, input int gap);
    button_i = mask;
    repeat (hold) step();
    button_i = '0;
    repeat (gap) step();
  endtask

  initial begin
    int bounce_on[9] = '{1, 0, 1, 1, 0, 1, 1, 1, 0};
    int bounce_off[8] = '{0, 1, 0, 0, 1, 1, 1, 0};
    int exp_steps[4] = '{32'h400000, 32'h200000, 32'h100000, 32'h080000};
    int vol_before;

    vecs[0] = '{1'b1, 1'b1, {24'h400000, 24'hC00000}, 1'b1, 1'b1, {24'h400000, 24'hC00000}};
    vecs[1] = '{1'b1, 1'b1, {24'h123456, 24'hFEDCBA}, 1'b1, 1'b1, {24'h123456, 24'hFEDCBA}};
    vecs[2] = '{1'b0, 1'b1, {24'h000000, 24'h000000}, 1'b0, 1'b1, {24'h123456, 24'hFEDCBA}};
    vecs[3] = '{1'b1, 1'b0, {24'h7FFFFF, 24'h800000}, 1'b1, 1'b0, {24'h7FFFFF, 24'h800000}};
    vecs[4] = '{1'b1, 1'b0, {24'h111111, 24'h222222}, 1'b1, 1'b0, {24'h7FFFFF, 24'h800000}};
    vecs[5] = '{1'b0, 1'b1, {24'h000000, 24'h000000}, 1'b0, 1'b1, {24'h7FFFFF, 24'h800000}};

    rstn_i = 1'b0; button_i = '0; valid_i = 1'b0; ready_i = 1'b1;
    data_left_i = '0; data_right_i = '0;
    stream_mode = 0; track_en = 1'b0;
    model_reset();
    #1;
    check("rst_valid", valid_o, 0);
    check("rst_ready", ready_o, 1);
    check("rst_led", led_o, 0);
    check("rst_left", u24(data_left_o), 0);
    repeat (2) @(posedge clk);
    #1 rstn_i = 1'b1;

    // Directed pass-through and handshake table at unity gain
    for (int i = 0; i < 6; i++) begin
      valid_i = vecs[i].v; ready_i = vecs[i].r;
      data_left_i = vecs[i].in.left; data_right_i = vecs[i].in.right;
      step();
      check($sformatf("vec%0d_valid", i), valid_o, vecs[i].ev);
      check($sformatf("vec%0d_ready", i), ready_o, vecs[i].er);
      check($sformatf("vec%0d_left", i), u24(data_left_o), u24(vecs[i].ex.left));
      check($sformatf("vec%0d_right", i), u24(data_right_o), u24(vecs[i].ex.right));
      check($sformatf("vec%0d_led", i), led_o, 0);
    end

    // Three volume-down presses: attenuation steps 0 -> 3
    stream_mode = 1; drive_stream();
    track_en = 1'b1;
    repeat (3) press(3'b010, 8, 10);
    repeat (20) step();
    track_en = 1'b0;
    check("t2_vol", led_o[4:2], 3);
    check("t2_left", u24(data_left_o), 24'h080000);
    check("t2_right", u24(data_right_o), 24'hF80000);
    check("t2_nsteps", track.size(), 4);
    for (int i = 0; i < 4 && i < track.size(); i++)
      check($sformatf("t2_step%0d", i), track[i], exp_steps[i]);

    // Mute ramp down and back up
    press(3'b001, 8, 40);
    check("t3_muted_led", led_o[1], 1);
    check("t3_muted_data", u24(data_left_o), 0);
    check("t3_muted_ramp", led_o[5], 0);
    press(3'b001, 8, 40);
    check("t3_play_led", led_o[1], 0);
    check("t3_play_ramp", led_o[5], 0);
    check("t3_play_left", u24(data_left_o), 24'h080000);

    // Bouncy volume-up press, long hold, bouncy release
    for (int i = 0; i < 9; i++) begin button_i[3] = bounce_on[i][0]; step(); end
    button_i[3] = 1'b1;
    repeat (100) step();
    for (int i = 0; i < 8; i++) begin button_i[3] = bounce_off[i][0]; step(); end
    button_i = '0;
    repeat (20) step();
    check("t4_vol_dec", led_o[4:2], 2);
    repeat (6) press(3'b010, 8, 8);
    check("t4_vol_sat", led_o[4:2], 7);

    // Downstream stall with a valid source
    stream_mode = 0; valid_i = 1'b1; ready_i = 1'b0;
    for (int i = 0; i < 10; i++) begin
      data_left_i = 24'($urandom); data_right_i = 24'($urandom);
      step();
      check("t5_valid_held", valid_o, 1);
      check("t5_ready_low", ready_o, 0);
    end

    // Randomized traffic and button activity
    stream_mode = 2; drive_stream();
    for (int n = 0; n < 40; n++) begin
      press(3'($urandom_range(1, 7)), $urandom_range(1, 10), $urandom_range(1, 40));
    end

    // Return to a settled PLAY state with room to raise the volume
    stream_mode = 1; drive_stream();
    repeat (60) step();
    if (m_state != PLAY) press(3'b001, 8, 60);
    if (m_vol == MS) press(3'b100, 8, 30);
    vol_before = m_vol;

    // Mute and volume-down together: mute wins, volume untouched
    press(3'b011, 8, 0);
    check("t6_rampdown", led_o[1], 1);
    check("t6_vol_kept", led_o[4:2], vol_before);
    check("t6_ramp_active", led_o[5], 1);
    step();
    #2 rstn_i = 1'b0;
    #1;
    model_reset();
    check("t6_rst_valid", valid_o, 0);
    check("t6_rst_ready", ready_o, 1);
    check("t6_rst_led", led_o, 0);
    check("t6_rst_left", u24(data_left_o), 0);
    repeat (2) step();
    rstn_i = 1'b1;
    repeat (10) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
